hurricane_scheduler: RTL and testbench



---
 rtl/hood_pkg.sv | 21 ++
 rtl/sec_tick_gen.sv | 33 +++
 rtl/hurricane_scheduler.sv | 140 ++++++++++++++
 tb/tb_hurricane_scheduler.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared range-hood definitions: fan mode encodings, scheduler states and the
// default tick rate.
package hood_pkg;

    localparam logic [2:0] MODE_STANDBY = 3'b000;
    localparam logic [2:0] MODE_1       = 3'b001;
    localparam logic [2:0] MODE_2       = 3'b010;
    localparam logic [2:0] MODE_3       = 3'b011;
    localparam logic [2:0] MODE_CLEAN   = 3'b100;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        READY  = 3'd1,
        RUN    = 3'd2,
        EXIT   = 3'd3,
        LOCKED = 3'd4
    } sched_state_t;

    localparam int DEFAULT_CLK_PER_SEC = 100_000_000;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler. Emits a one-cycle tick at terminal count.
// Also reused by the self-clean timer.
module sec_tick_gen
    import hood_pkg::*;
#(
    parameter int CLK_PER_SEC = DEFAULT_CLK_PER_SEC
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == TERM);

    // clr wins over en so a fresh countdown always starts with a full second
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hurricane_scheduler.sv
// Hurricane (mode 3) scheduler: arms once per power-on session, runs the
// countdown, forces the exit and picks the exit target (mode 2 or standby).
module hurricane_scheduler
    import hood_pkg::*;
#(
    parameter int CLK_PER_SEC   = DEFAULT_CLK_PER_SEC,
    parameter int HURRICANE_SEC = 60,
    parameter int SEC_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             machine_state,
    input  logic [2:0]       mode_state,
    input  logic             menu_btn,
    output logic             hurricane_mode_enabled,
    output logic             return_state,
    output logic             countdown_active,
    output logic [SEC_W-1:0] remain_sec,
    output logic             locked
);

    sched_state_t     state_q, state_d;
    logic             en_d, ret_d, act_d, lock_d;
    logic [SEC_W-1:0] rem_d;
    logic             tick;
    logic             in_run;
    logic             mode3;

    assign in_run = (state_q == RUN);
    assign mode3  = (mode_state == MODE_3);

    sec_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (in_run),
        .clr  (!in_run),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        en_d    = hurricane_mode_enabled;
        ret_d   = return_state;
        act_d   = countdown_active;
        rem_d   = remain_sec;
        lock_d  = locked;
        if (!machine_state) begin
            // power-off ends the session and clears the lockout
            state_d = OFF;
            en_d    = 1'b0;
            ret_d   = 1'b0;
            act_d   = 1'b0;
            rem_d   = '0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = READY;
                    en_d    = 1'b1;
                    ret_d   = 1'b0;
                    act_d   = 1'b0;
                    rem_d   = '0;
                    lock_d  = 1'b0;
                end
                READY: begin
                    en_d = 1'b1;
                    if (mode3) begin
                        state_d = RUN;
                        rem_d   = SEC_W'(HURRICANE_SEC);
                        ret_d   = 1'b0;
                        act_d   = 1'b1;
                    end
                end
                RUN: begin
                    if (!mode3) begin
                        state_d = LOCKED;
                        en_d    = 1'b0;
                        act_d   = 1'b0;
                        rem_d   = '0;
                        ret_d   = 1'b0;
                        lock_d  = 1'b1;
                    end else if (tick && remain_sec == SEC_W'(1)) begin
                        // expiry: a menu press on this cycle is deliberately dropped
                        state_d = EXIT;
                        en_d    = 1'b0;
                        act_d   = 1'b0;
                        rem_d   = '0;
                    end else begin
                        if (tick && remain_sec != '0) begin
                            rem_d = remain_sec - SEC_W'(1);
                        end
                        if (menu_btn) begin
                            ret_d = !return_state;
                        end
                    end
                end
                EXIT: begin
                    en_d = 1'b0;
                    if (!mode3) begin
                        state_d = LOCKED;
                        lock_d  = 1'b1;
                        ret_d   = 1'b0;
                    end
                end
                LOCKED: begin
                    en_d   = 1'b0;
                    lock_d = 1'b1;
                    ret_d  = 1'b0;
                end
                default: begin
                    state_d = OFF;
                    en_d    = 1'b0;
                    ret_d   = 1'b0;
                    act_d   = 1'b0;
                    rem_d   = '0;
                    lock_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                <= OFF;
            hurricane_mode_enabled <= 1'b0;
            return_state           <= 1'b0;
            countdown_active       <= 1'b0;
            remain_sec             <= '0;
            locked                 <= 1'b0;
        end else begin
            state_q                <= state_d;
            hurricane_mode_enabled <= en_d;
            return_state           <= ret_d;
            countdown_active       <= act_d;
            remain_sec             <= rem_d;
            locked                 <= lock_d;
        end
    end

endmodule

// File: tb/tb_hurricane_scheduler.sv
// Directed bench for hurricane_scheduler with CLK_PER_SEC = 10, HURRICANE_SEC = 3.
// Expected exit targets are queued when each run is launched and popped at expiry.
module tb_hurricane_scheduler;

    localparam int CPS   = 10;
    localparam int HSEC  = 3;
    localparam int SEC_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             machine_state = 1'b0;
    logic [2:0]       mode_state = 3'b000;
    logic             menu_btn = 1'b0;
    logic             hurricane_mode_enabled;
    logic             return_state;
    logic             countdown_active;
    logic [SEC_W-1:0] remain_sec;
    logic             locked;

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    hurricane_scheduler #(
        .CLK_PER_SEC   (CPS),
        .HURRICANE_SEC (HSEC),
        .SEC_W         (SEC_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .machine_state          (machine_state),
        .mode_state             (mode_state),
        .menu_btn               (menu_btn),
        .hurricane_mode_enabled (hurricane_mode_enabled),
        .return_state           (return_state),
        .countdown_active       (countdown_active),
        .remain_sec             (remain_sec),
        .locked                 (locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " enable"}, 32'(hurricane_mode_enabled), 0);
        check({tag, " return"}, 32'(return_state), 0);
        check({tag, " active"}, 32'(countdown_active), 0);
        check({tag, " remain"}, 32'(remain_sec), 0);
        check({tag, " locked"}, 32'(locked), 0);
    endtask

    // Launch a run, press menu at cycles p1/p2 (0 = none), wait for expiry.
    task automatic do_run(input string tag, input int p1, input int p2, input logic exp_ret);
        int   k_hit;
        logic exp;
        k_hit = 0;
        exp_q.push_back(exp_ret);
        mode_state = 3'b011;
        @(negedge clk);
        check({tag, " start active"}, 32'(countdown_active), 1);
        check({tag, " start remain"}, 32'(remain_sec), HSEC);
        check({tag, " start return"}, 32'(return_state), 0);
        for (int k = 1; k <= 40; k++) begin
            menu_btn = (k == p1) || (k == p2);
            @(negedge clk);
            menu_btn = 1'b0;
            if (k == 9)  check({tag, " remain@9"},  32'(remain_sec), 3);
            if (k == 10) check({tag, " remain@10"}, 32'(remain_sec), 2);
            if (k == 20) check({tag, " remain@20"}, 32'(remain_sec), 1);
            if (k == 29) check({tag, " enable@29"}, 32'(hurricane_mode_enabled), 1);
            if (!hurricane_mode_enabled) begin
                k_hit = k;
                break;
            end
        end
        check({tag, " expiry cycle"}, 32'(k_hit), 30);
        check({tag, " expiry remain"}, 32'(remain_sec), 0);
        check({tag, " expiry active"}, 32'(countdown_active), 0);
        exp = exp_q.pop_front();
        check({tag, " exit target"}, 32'(return_state), 32'(exp));
        // menu in EXIT must not disturb the frozen target
        menu_btn = 1'b1;
        @(negedge clk);
        menu_btn = 1'b0;
        check({tag, " exit frozen"}, 32'(return_state), 32'(exp));
        check({tag, " exit enable"}, 32'(hurricane_mode_enabled), 0);
        mode_state = (exp == 1'b1) ? 3'b010 : 3'b000;
        @(negedge clk);
        check({tag, " lock locked"}, 32'(locked), 1);
        check({tag, " lock enable"}, 32'(hurricane_mode_enabled), 0);
        check({tag, " lock return"}, 32'(return_state), 0);
        repeat (3) @(negedge clk);
        check({tag, " lock held"}, 32'(hurricane_mode_enabled), 0);
    endtask

    task automatic power_cycle(input string tag);
        mode_state    = 3'b000;
        machine_state = 1'b0;
        @(negedge clk);
        check_idle({tag, " off"});
        machine_state = 1'b1;
        @(negedge clk);
        check({tag, " on enable"}, 32'(hurricane_mode_enabled), 1);
        check({tag, " on locked"}, 32'(locked), 0);
    endtask

    initial begin
        #2;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("off after reset");
        machine_state = 1'b1;
        @(negedge clk);
        check({"ready enable"}, 32'(hurricane_mode_enabled), 1);
        check({"ready locked"}, 32'(locked), 0);

        do_run("run0", 0, 0, 1'b0);
        power_cycle("pc0");
        do_run("run1", 15, 0, 1'b1);
        power_cycle("pc1");
        do_run("run2", 15, 18, 1'b0);
        power_cycle("pc2");
        do_run("run3", 15, 30, 1'b1);
        power_cycle("pc3");

        // external exit from RUN at cycle 12
        mode_state = 3'b011;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            if (k == 12) mode_state = 3'b010;
            @(negedge clk);
        end
        check("ext locked", 32'(locked), 1);
        check("ext active", 32'(countdown_active), 0);
        check("ext remain", 32'(remain_sec), 0);
        check("ext enable", 32'(hurricane_mode_enabled), 0);
        power_cycle("pc4");

        // asynchronous reset mid-run
        mode_state = 3'b011;
        @(negedge clk);
        repeat (16) @(negedge clk);
        check("pre-rst remain", 32'(remain_sec), 2);
        #2;
        rst = 1'b0;
        #1;
        check_idle("async rst");
        @(negedge clk);
        mode_state = 3'b000;
        rst = 1'b1;
        @(negedge clk);
        check("rst release enable", 32'(hurricane_mode_enabled), 1);
        check("rst release locked", 32'(locked), 0);

        // power off with mode 3 held: nothing starts
        machine_state = 1'b0;
        mode_state    = 3'b011;
        repeat (3) @(negedge clk);
        check_idle("off mode3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
